// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: shadows EX/MEM/WB destination
// metadata, drives operand forwarding selects, load-use stalls and branch flushes.
module hazard_forward_unit #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int CNT_BITWIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
    input  logic                        id_use_rs1,
    input  logic                        id_use_rs2,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rd,
    input  logic                        id_regWrite,
    input  logic                        id_memRead,
    input  logic                        ex_branch_taken,
    output logic [1:0]                  forwardA,
    output logic [1:0]                  forwardB,
    output logic                        pc_write,
    output logic                        ifid_write,
    output logic                        ifid_flush,
    output logic                        idex_flush,
    output logic [CNT_BITWIDTH-1:0]     stall_count,
    output logic [CNT_BITWIDTH-1:0]     flush_count
);

    localparam logic [REG_NUM_BITWIDTH-1:0] REG_ZERO = '0;
    localparam logic [CNT_BITWIDTH-1:0]     CNT_MAX  = '1;
    localparam logic [CNT_BITWIDTH-1:0]     CNT_ONE  = CNT_BITWIDTH'(1);

    logic [REG_NUM_BITWIDTH-1:0] idex_rs1_q, idex_rs1_d;
    logic [REG_NUM_BITWIDTH-1:0] idex_rs2_q, idex_rs2_d;
    logic                        idex_use_rs1_q, idex_use_rs1_d;
    logic                        idex_use_rs2_q, idex_use_rs2_d;
    logic [REG_NUM_BITWIDTH-1:0] idex_rd_q, idex_rd_d;
    logic                        idex_reg_write_q, idex_reg_write_d;
    logic                        idex_mem_read_q, idex_mem_read_d;

    // A load's memRead only matters while it sits in EX, so later stages keep rd/regWrite.
    logic [REG_NUM_BITWIDTH-1:0] exmem_rd_q, exmem_rd_d;
    logic                        exmem_reg_write_q, exmem_reg_write_d;
    logic [REG_NUM_BITWIDTH-1:0] memwb_rd_q, memwb_rd_d;
    logic                        memwb_reg_write_q, memwb_reg_write_d;

    logic [CNT_BITWIDTH-1:0]     stall_count_q, stall_count_d;
    logic [CNT_BITWIDTH-1:0]     flush_count_q, flush_count_d;

    logic                        loaduse;
    logic [1:0]                  fwd_a;
    logic [1:0]                  fwd_b;

    assign loaduse = id_valid && idex_mem_read_q && (idex_rd_q != REG_ZERO) &&
                     ((id_use_rs1 && (id_rs1 == idex_rd_q)) ||
                      (id_use_rs2 && (id_rs2 == idex_rd_q)));

    // EX/MEM wins over MEM/WB so the youngest producer supplies the operand.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (exmem_reg_write_q && (exmem_rd_q != REG_ZERO) &&
            (exmem_rd_q == idex_rs1_q) && idex_use_rs1_q) begin
            fwd_a = 2'b10;
        end else if (memwb_reg_write_q && (memwb_rd_q != REG_ZERO) &&
                     (memwb_rd_q == idex_rs1_q) && idex_use_rs1_q) begin
            fwd_a = 2'b01;
        end
        if (exmem_reg_write_q && (exmem_rd_q != REG_ZERO) &&
            (exmem_rd_q == idex_rs2_q) && idex_use_rs2_q) begin
            fwd_b = 2'b10;
        end else if (memwb_reg_write_q && (memwb_rd_q != REG_ZERO) &&
                     (memwb_rd_q == idex_rs2_q) && idex_use_rs2_q) begin
            fwd_b = 2'b01;
        end
    end

    assign forwardA = fwd_a;
    assign forwardB = fwd_b;

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (loaduse) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        idex_rs1_d        = id_rs1;
        idex_rs2_d        = id_rs2;
        idex_use_rs1_d    = id_use_rs1;
        idex_use_rs2_d    = id_use_rs2;
        idex_rd_d         = id_rd;
        idex_reg_write_d  = id_regWrite && id_valid;
        idex_mem_read_d   = id_memRead && id_valid;
        if (idex_flush) begin
            idex_rs1_d       = REG_ZERO;
            idex_rs2_d       = REG_ZERO;
            idex_use_rs1_d   = 1'b0;
            idex_use_rs2_d   = 1'b0;
            idex_rd_d        = REG_ZERO;
            idex_reg_write_d = 1'b0;
            idex_mem_read_d  = 1'b0;
        end

        exmem_rd_d        = idex_rd_q;
        exmem_reg_write_d = idex_reg_write_q;
        memwb_rd_d        = exmem_rd_q;
        memwb_reg_write_d = exmem_reg_write_q;

        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (ex_branch_taken) begin
            if (flush_count_q != CNT_MAX) flush_count_d = flush_count_q + CNT_ONE;
        end else if (loaduse) begin
            if (stall_count_q != CNT_MAX) stall_count_d = stall_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_rs1_q        <= '0;
            idex_rs2_q        <= '0;
            idex_use_rs1_q    <= 1'b0;
            idex_use_rs2_q    <= 1'b0;
            idex_rd_q         <= '0;
            idex_reg_write_q  <= 1'b0;
            idex_mem_read_q   <= 1'b0;
            exmem_rd_q        <= '0;
            exmem_reg_write_q <= 1'b0;
            memwb_rd_q        <= '0;
            memwb_reg_write_q <= 1'b0;
            stall_count_q     <= '0;
            flush_count_q     <= '0;
        end else begin
            idex_rs1_q        <= idex_rs1_d;
            idex_rs2_q        <= idex_rs2_d;
            idex_use_rs1_q    <= idex_use_rs1_d;
            idex_use_rs2_q    <= idex_use_rs2_d;
            idex_rd_q         <= idex_rd_d;
            idex_reg_write_q  <= idex_reg_write_d;
            idex_mem_read_q   <= idex_mem_read_d;
            exmem_rd_q        <= exmem_rd_d;
            exmem_reg_write_q <= exmem_reg_write_d;
            memwb_rd_q        <= memwb_rd_d;
            memwb_reg_write_q <= memwb_reg_write_d;
            stall_count_q     <= stall_count_d;
            flush_count_q     <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
